// File: rtl/dpram_arb_pkg.sv
// dpram_arb_pkg: shared client encoding and constants for the dual-port RAM arbiter
package dpram_arb_pkg;
  typedef enum logic {CLIENT_A = 1'b0, CLIENT_B = 1'b1} client_e;
  localparam client_e RST_PTR = CLIENT_A;
  localparam int RD_LATENCY = 2;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin arbiter; the pointer moves to the other client after any grant
import dpram_arb_pkg::*;
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] gnt
);
  client_e ptr;
  // pointer holder wins a tie; a lone requester always wins
  always_comb begin
    gnt[0] = req[0] & ((ptr == CLIENT_A) | ~req[1]);
    gnt[1] = req[1] & ((ptr == CLIENT_B) | ~req[0]);
  end
  // hand priority to the client that was not just served
  always_ff @(posedge clk)
    if (rst) ptr <= RST_PTR;
    else if (|gnt) ptr <= gnt[0] ? CLIENT_B : CLIENT_A;
endmodule

// File: rtl/dpram_rr_arbiter.sv
// dpram_rr_arbiter: shares one dual-port RAM between clients A and B with per-port round-robin
import dpram_arb_pkg::*;
module dpram_rr_arbiter #(
  parameter int DATA_WIDTH    = 16,
  parameter int ADDRESS_SIZE  = 3,
  parameter int ADDRESS_DEPTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    a_wr_req,
  input  logic [ADDRESS_SIZE-1:0] a_wr_addr,
  input  logic [DATA_WIDTH-1:0]   a_wr_data,
  output logic                    a_wr_gnt,
  input  logic                    a_rd_req,
  input  logic [ADDRESS_SIZE-1:0] a_rd_addr,
  output logic                    a_rd_gnt,
  output logic                    a_rd_valid,
  output logic [DATA_WIDTH-1:0]   a_rd_data,
  input  logic                    b_wr_req,
  input  logic [ADDRESS_SIZE-1:0] b_wr_addr,
  input  logic [DATA_WIDTH-1:0]   b_wr_data,
  output logic                    b_wr_gnt,
  input  logic                    b_rd_req,
  input  logic [ADDRESS_SIZE-1:0] b_rd_addr,
  output logic                    b_rd_gnt,
  output logic                    b_rd_valid,
  output logic [DATA_WIDTH-1:0]   b_rd_data,
  output logic                    ram_we,
  output logic [ADDRESS_SIZE-1:0] ram_wr_addr,
  output logic [DATA_WIDTH-1:0]   ram_wr_data,
  output logic                    ram_re,
  output logic [ADDRESS_SIZE-1:0] ram_rd_addr,
  input  logic [DATA_WIDTH-1:0]   ram_rd_data
);
  if (ADDRESS_DEPTH != 2 ** ADDRESS_SIZE) begin : g_bad_depth
    $error("ADDRESS_DEPTH must equal 2**ADDRESS_SIZE");
  end
  logic [1:0] wg, rg;
  logic [DATA_WIDTH-1:0] rd_word;
  client_e rd_own;
  rr_arb2 u_wr_arb (.clk(clk), .rst(rst), .req({b_wr_req, a_wr_req} & {2{~rst}}), .gnt(wg));
  rr_arb2 u_rd_arb (.clk(clk), .rst(rst), .req({b_rd_req, a_rd_req} & {2{~rst}}), .gnt(rg));
  assign {b_wr_gnt, a_wr_gnt} = wg;
  assign {b_rd_gnt, a_rd_gnt} = rg;
  // write-first: a same-cycle write to the read address overrides the stale RAM word
  assign rd_word = (ram_we && ram_wr_addr == ram_rd_addr) ? ram_wr_data : ram_rd_data;
  // register the granted command; addr/data hold when idle
  always_ff @(posedge clk)
    if (rst) begin
      ram_we      <= 1'b0;
      ram_wr_addr <= '0;
      ram_wr_data <= '0;
      ram_re      <= 1'b0;
      ram_rd_addr <= '0;
      rd_own      <= CLIENT_A;
    end else begin
      ram_we <= |wg;
      ram_re <= |rg;
      if (|wg) begin
        ram_wr_addr <= wg[1] ? b_wr_addr : a_wr_addr;
        ram_wr_data <= wg[1] ? b_wr_data : a_wr_data;
      end
      if (|rg) begin
        ram_rd_addr <= rg[1] ? b_rd_addr : a_rd_addr;
        rd_own      <= rg[1] ? CLIENT_B : CLIENT_A;
      end
    end
  // capture the read word and steer the valid pulse to the owning client
  always_ff @(posedge clk)
    if (rst) begin
      a_rd_valid <= 1'b0;
      b_rd_valid <= 1'b0;
      a_rd_data  <= '0;
      b_rd_data  <= '0;
    end else begin
      a_rd_valid <= ram_re && rd_own == CLIENT_A;
      b_rd_valid <= ram_re && rd_own == CLIENT_B;
      if (ram_re && rd_own == CLIENT_A) a_rd_data <= rd_word;
      if (ram_re && rd_own == CLIENT_B) b_rd_data <= rd_word;
    end
  logic [3:0] req_v, gnt_v;
  assign req_v = {b_rd_req, a_rd_req, b_wr_req, a_wr_req};
  assign gnt_v = {b_rd_gnt, a_rd_gnt, b_wr_gnt, a_wr_gnt};
  for (genvar g = 0; g < 4; g++) begin : g_hold
    assert property (@(posedge clk) disable iff (rst) req_v[g] && !gnt_v[g] |=> req_v[g])
      else $error("request %0d dropped before grant", g);
  end
endmodule

// File: tb/tb_dpram_rr_arbiter.sv
// tb_dpram_rr_arbiter: table vectors, directed corner cases and random traffic against a scoreboard
module tb_dpram_rr_arbiter;
  import dpram_arb_pkg::*;
  localparam int DW = 16, AS = 3, DEPTH = 8;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  logic a_wr_req = 0, b_wr_req = 0, a_rd_req = 0, b_rd_req = 0;
  logic [AS-1:0] a_wr_addr = 0, b_wr_addr = 0, a_rd_addr = 0, b_rd_addr = 0;
  logic [DW-1:0] a_wr_data = 0, b_wr_data = 0;
  logic a_wr_gnt, b_wr_gnt, a_rd_gnt, b_rd_gnt, a_rd_valid, b_rd_valid;
  logic [DW-1:0] a_rd_data, b_rd_data, ram_wr_data, ram_rd_data;
  logic ram_we, ram_re;
  logic [AS-1:0] ram_wr_addr, ram_rd_addr;

  dpram_rr_arbiter #(.DATA_WIDTH(DW), .ADDRESS_SIZE(AS), .ADDRESS_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .a_wr_req(a_wr_req), .a_wr_addr(a_wr_addr), .a_wr_data(a_wr_data), .a_wr_gnt(a_wr_gnt),
    .a_rd_req(a_rd_req), .a_rd_addr(a_rd_addr), .a_rd_gnt(a_rd_gnt),
    .a_rd_valid(a_rd_valid), .a_rd_data(a_rd_data),
    .b_wr_req(b_wr_req), .b_wr_addr(b_wr_addr), .b_wr_data(b_wr_data), .b_wr_gnt(b_wr_gnt),
    .b_rd_req(b_rd_req), .b_rd_addr(b_rd_addr), .b_rd_gnt(b_rd_gnt),
    .b_rd_valid(b_rd_valid), .b_rd_data(b_rd_data),
    .ram_we(ram_we), .ram_wr_addr(ram_wr_addr), .ram_wr_data(ram_wr_data),
    .ram_re(ram_re), .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_rd_data)
  );

  // the RAM itself: asynchronous read, written on the clock, never reset by rst
  logic [DW-1:0] mem [DEPTH];
  initial for (int i = 0; i < DEPTH; i++) mem[i] = '0;
  always @(posedge clk) if (ram_we) mem[ram_wr_addr] <= ram_wr_data;
  assign ram_rd_data = mem[ram_rd_addr];

  // scoreboard: requests 0=a_wr 1=b_wr 2=a_rd 3=b_rd
  typedef struct {int due; int cl; logic [DW-1:0] d;} rd_t;
  rd_t q[$];
  logic p_req [4];
  logic [AS-1:0] p_addr [4];
  logic [DW-1:0] p_data [4];
  logic [DW-1:0] shadow [DEPTH];
  logic [DW-1:0] held [2];
  int last_win [2];
  logic e_we, e_re;
  logic [AS-1:0] e_wa, e_ra;
  logic [DW-1:0] e_wd;
  int cyc = 0, tests = 0, fails = 0;
  logic [3:0] s_g;
  logic s_arv;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", n, cyc, act, exp);
    end
  endtask

  // round robin by definition: with both asking, the one not served last time wins
  function automatic int pick(input logic ra, input logic rb, input int last);
    if (ra && rb) return 1 - last;
    if (ra) return 0;
    if (rb) return 1;
    return -1;
  endfunction

  task automatic model_reset();
    last_win[0] = 1; last_win[1] = 1;
    e_we = 0; e_re = 0; e_wa = 0; e_ra = 0; e_wd = 0;
    held[0] = 0; held[1] = 0;
    q.delete();
  endtask

  task automatic rq(input int i, input logic [AS-1:0] a, input logic [DW-1:0] d);
    p_req[i] = 1; p_addr[i] = a; p_data[i] = d;
  endtask

  task automatic step();
    int w, r;
    logic va, vb;
    rd_t e;
    a_wr_req = p_req[0]; a_wr_addr = p_addr[0]; a_wr_data = p_data[0];
    b_wr_req = p_req[1]; b_wr_addr = p_addr[1]; b_wr_data = p_data[1];
    a_rd_req = p_req[2]; a_rd_addr = p_addr[2];
    b_rd_req = p_req[3]; b_rd_addr = p_addr[3];
    @(negedge clk);
    w = rst ? -1 : pick(p_req[0], p_req[1], last_win[0]);
    r = rst ? -1 : pick(p_req[2], p_req[3], last_win[1]);
    s_g = {b_rd_gnt, a_rd_gnt, b_wr_gnt, a_wr_gnt};
    s_arv = a_rd_valid;
    chk("a_wr_gnt", a_wr_gnt, w == 0);
    chk("b_wr_gnt", b_wr_gnt, w == 1);
    chk("a_rd_gnt", a_rd_gnt, r == 0);
    chk("b_rd_gnt", b_rd_gnt, r == 1);
    chk("wr_gnt_onehot", a_wr_gnt & b_wr_gnt, 0);
    chk("rd_gnt_onehot", a_rd_gnt & b_rd_gnt, 0);
    chk("ram_we", ram_we, e_we);
    chk("ram_wr_addr", ram_wr_addr, e_wa);
    chk("ram_wr_data", ram_wr_data, e_wd);
    chk("ram_re", ram_re, e_re);
    chk("ram_rd_addr", ram_rd_addr, e_ra);
    va = 0; vb = 0;
    if (q.size() > 0 && q[0].due == cyc) begin
      if (q[0].cl == 0) begin va = 1; held[0] = q[0].d; end
      else begin vb = 1; held[1] = q[0].d; end
      void'(q.pop_front());
    end
    chk("a_rd_valid", a_rd_valid, va);
    chk("b_rd_valid", b_rd_valid, vb);
    chk("a_rd_data", a_rd_data, held[0]);
    chk("b_rd_data", b_rd_data, held[1]);
    if (rst) model_reset();
    else begin
      e_we = w >= 0;
      if (w >= 0) begin
        last_win[0] = w; e_wa = p_addr[w]; e_wd = p_data[w]; shadow[e_wa] = e_wd;
      end
      e_re = r >= 0;
      if (r >= 0) begin
        last_win[1] = r; e_ra = p_addr[2 + r];
        e.due = cyc + RD_LATENCY; e.cl = r; e.d = shadow[e_ra];
        q.push_back(e);
      end
    end
    @(posedge clk);
    cyc++;
    #1;
    if (w >= 0) p_req[w] = 0;
    if (r >= 0) p_req[2 + r] = 0;
  endtask

  task automatic drain();
    int n = 0;
    while ((p_req[0] || p_req[1] || p_req[2] || p_req[3] || q.size() > 0) && n < 40) begin
      step();
      n++;
    end
    chk("drain_bound", n < 40, 1);
  endtask

  task automatic pulse_rst();
    rst = 1;
    step();
    rst = 0;
  endtask

  typedef struct {logic [1:0] wr, rd, ewg, erg;} vec_t;
  vec_t tbl [9];

  initial begin
    // {b,a} request bits and the grant each must earn, starting from reset
    tbl[0] = '{2'b11, 2'b10, 2'b01, 2'b10};
    tbl[1] = '{2'b10, 2'b11, 2'b10, 2'b01};
    tbl[2] = '{2'b01, 2'b10, 2'b01, 2'b10};
    tbl[3] = '{2'b11, 2'b01, 2'b10, 2'b01};
    tbl[4] = '{2'b01, 2'b11, 2'b01, 2'b10};
    tbl[5] = '{2'b00, 2'b01, 2'b00, 2'b01};
    tbl[6] = '{2'b10, 2'b00, 2'b10, 2'b00};
    tbl[7] = '{2'b11, 2'b11, 2'b01, 2'b10};
    tbl[8] = '{2'b10, 2'b01, 2'b10, 2'b01};
    for (int i = 0; i < 4; i++) begin p_req[i] = 0; p_addr[i] = 0; p_data[i] = 0; end
    for (int i = 0; i < DEPTH; i++) shadow[i] = '0;
    model_reset();
    @(posedge clk);
    #1;
    // reset held with every request raised
    for (int i = 0; i < 4; i++) rq(i, AS'(i), 16'h1000 + 16'(i));
    repeat (3) step();
    rst = 0;
    step();
    chk("rst_first_grant_a", s_g, 4'b0101);
    drain();
    // table of grant vectors
    pulse_rst();
    for (int k = 0; k < 9; k++) begin
      for (int i = 0; i < 2; i++) begin
        if (tbl[k].wr[i] && !p_req[i]) rq(i, AS'(k), 16'h2000 + 16'(k * 2 + i));
        if (tbl[k].rd[i] && !p_req[2 + i]) rq(2 + i, AS'(k + i), 0);
      end
      step();
      chk($sformatf("tbl%0d_wr", k), s_g[1:0], tbl[k].ewg);
      chk($sformatf("tbl%0d_rd", k), s_g[3:2], tbl[k].erg);
    end
    drain();
    // single client write then read back
    pulse_rst();
    rq(0, 3, 16'hBEEF);
    drain();
    rq(2, 3, 0);
    drain();
    chk("single_a_rd_data", a_rd_data, 16'hBEEF);
    // sustained contention on both ports
    pulse_rst();
    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < 4; i++) if (!p_req[i]) rq(i, AS'(k), 16'h3000 + 16'(k * 4 + i));
      step();
      chk($sformatf("cont%0d_wr", k), s_g[1:0], (k % 2) ? 2'b10 : 2'b01);
      chk($sformatf("cont%0d_rd", k), s_g[3:2], (k % 2) ? 2'b10 : 2'b01);
    end
    drain();
    // write-first bypass: B writes @5 while A reads @5 holding 0
    pulse_rst();
    rq(0, 5, 16'h0000);
    drain();
    rq(1, 5, 16'h1234);
    rq(2, 5, 0);
    step();
    chk("bypass_gnt", s_g, 4'b0110);
    drain();
    chk("bypass_a_rd_data", a_rd_data, 16'h1234);
    // reset the cycle after a read grant
    pulse_rst();
    rq(2, 3, 0);
    step();
    chk("midrst_gnt", s_g[2], 1);
    rst = 1;
    step();
    rst = 0;
    for (int i = 0; i < 4; i++) rq(i, AS'(i), 16'h4000 + 16'(i));
    step();
    chk("midrst_no_valid", s_arv, 0);
    chk("midrst_ptr_a", s_g, 4'b0101);
    drain();
    // full sweep: alternating writers, then both clients read everything
    pulse_rst();
    for (int k = 0; k < DEPTH; k++) begin
      rq(k % 2, AS'(k), 16'($urandom));
      drain();
    end
    for (int k = 0; k < DEPTH; k++) begin
      rq(2, AS'(k), 0);
      rq(3, AS'(DEPTH - 1 - k), 0);
      drain();
    end
    // random traffic with occasional resets
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < 4; i++)
        if (!p_req[i] && $urandom_range(0, 2) != 0) rq(i, AS'($urandom_range(0, DEPTH - 1)), 16'($urandom));
      rst = ($urandom_range(0, 99) == 0);
      step();
    end
    rst = 0;
    drain();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
